// File: rtl/decode_stage_v2.sv
// Decode stage: splits the instruction word, reads three operands from a bypassed
// register file, detects load-use hazards and holds the result in the ID/EX register.
module decode_stage_v2 #(
  parameter int DATA_W    = 24,
  parameter int PC_W      = 24,
  parameter int REG_IDX_W = 4,
  parameter int IMM_W     = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          inst,
  input  logic [PC_W-1:0]      pc,
  input  logic                 out_ready,
  input  logic                 flush,
  input  logic                 wb_we,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]    wb_wd,
  output logic                 ex_valid,
  output logic [PC_W-1:0]      ex_pc,
  output logic [1:0]           ex_op_type,
  output logic [3:0]           ex_op_code,
  output logic                 ex_imm_src,
  output logic                 ex_branch,
  output logic                 ex_mem_write,
  output logic                 ex_mem_to_reg,
  output logic                 ex_reg_write,
  output logic [3:0]           ex_alu_ctrl,
  output logic [REG_IDX_W-1:0] ex_ra,
  output logic [REG_IDX_W-1:0] ex_rb,
  output logic [REG_IDX_W-1:0] ex_rc,
  output logic [DATA_W-1:0]    ex_rd1,
  output logic [DATA_W-1:0]    ex_rd2,
  output logic [DATA_W-1:0]    ex_rd3,
  output logic [DATA_W-1:0]    ex_imm,
  output logic                 hazard_stall
);

  localparam int NumRegs = 2**REG_IDX_W;
  localparam int RcLo    = 26 - REG_IDX_W;
  localparam int RaLo    = RcLo - REG_IDX_W;
  localparam int RbLo    = RaLo - REG_IDX_W;

  typedef struct packed {
    logic [PC_W-1:0]      pc;
    logic [1:0]           opType;
    logic [3:0]           opCode;
    logic                 immSrc;
    logic                 branch;
    logic                 memWrite;
    logic                 memToReg;
    logic                 regWrite;
    logic [3:0]           aluCtrl;
    logic [REG_IDX_W-1:0] ra;
    logic [REG_IDX_W-1:0] rb;
    logic [REG_IDX_W-1:0] rc;
    logic [DATA_W-1:0]    rd1;
    logic [DATA_W-1:0]    rd2;
    logic [DATA_W-1:0]    rd3;
    logic [DATA_W-1:0]    imm;
  } bundle_t;

  logic [DATA_W-1:0]        regFile_q [NumRegs];
  logic [1:0]               opType;
  logic [3:0]               opCode;
  logic [REG_IDX_W-1:0]     raIdx, rbIdx, rcIdx;
  logic signed [IMM_W-1:0]  immRaw;
  logic [DATA_W-1:0]        rdA, rdB, rdC;
  logic                     isStore, advance, hazard;
  bundle_t                  decBundle, exBundle_q, exBundle_d;
  logic                     exValid_q, exValid_d;

  assign opType = inst[31:30];
  assign opCode = inst[29:26];
  assign rcIdx  = inst[RcLo +: REG_IDX_W];
  assign raIdx  = inst[RaLo +: REG_IDX_W];
  assign rbIdx  = inst[RbLo +: REG_IDX_W];
  assign immRaw = inst[IMM_W-1:0];

  // Same-cycle write-back is forwarded so decode never sees a stale operand.
  assign rdA = (wb_we && wb_rd == raIdx) ? wb_wd : regFile_q[raIdx];
  assign rdB = (wb_we && wb_rd == rbIdx) ? wb_wd : regFile_q[rbIdx];
  assign rdC = (wb_we && wb_rd == rcIdx) ? wb_wd : regFile_q[rcIdx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) regFile_q[i] <= '0;
    end else if (wb_we) begin
      regFile_q[wb_rd] <= wb_wd;
    end
  end

  always_comb begin
    decBundle         = '0;
    decBundle.pc      = pc;
    decBundle.opType  = opType;
    decBundle.opCode  = opCode;
    decBundle.aluCtrl = opCode;
    decBundle.ra      = raIdx;
    decBundle.rb      = rbIdx;
    decBundle.rc      = rcIdx;
    decBundle.rd1     = rdA;
    decBundle.rd2     = rdB;
    decBundle.rd3     = rdC;
    decBundle.imm     = DATA_W'(immRaw);
    case (opType)
      2'b00: decBundle.regWrite = 1'b1;
      2'b01: begin
        decBundle.regWrite = 1'b1;
        decBundle.immSrc   = 1'b1;
      end
      2'b10: begin
        decBundle.immSrc = 1'b1;
        if (opCode[0]) begin
          decBundle.memWrite = 1'b1;
        end else begin
          decBundle.memToReg = 1'b1;
          decBundle.regWrite = 1'b1;
        end
      end
      default: begin
        decBundle.branch = 1'b1;
        decBundle.immSrc = 1'b1;
      end
    endcase
  end

  // A store also reads rc (its data operand), so it must wait on a pending load into rc.
  assign isStore = (opType == 2'b10) & opCode[0];
  assign advance = out_ready | ~exValid_q;
  assign hazard  = in_valid & exValid_q & exBundle_q.memToReg &
                   ((exBundle_q.rc == raIdx) | (exBundle_q.rc == rbIdx) |
                    (isStore & (exBundle_q.rc == rcIdx)));

  assign in_ready     = ~rst & advance & ~hazard & ~flush;
  assign hazard_stall = ~rst & advance & hazard & ~flush;

  always_comb begin
    exValid_d  = exValid_q;
    exBundle_d = exBundle_q;
    if (flush) begin
      exValid_d = 1'b0;
    end else if (advance) begin
      exValid_d = in_valid & in_ready;
      if (in_valid && in_ready) exBundle_d = decBundle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exValid_q  <= 1'b0;
      exBundle_q <= '0;
    end else begin
      exValid_q  <= exValid_d;
      exBundle_q <= exBundle_d;
    end
  end

  assign ex_valid      = exValid_q;
  assign ex_pc         = exBundle_q.pc;
  assign ex_op_type    = exBundle_q.opType;
  assign ex_op_code    = exBundle_q.opCode;
  assign ex_imm_src    = exBundle_q.immSrc;
  assign ex_branch     = exBundle_q.branch;
  assign ex_mem_write  = exBundle_q.memWrite;
  assign ex_mem_to_reg = exBundle_q.memToReg;
  assign ex_reg_write  = exBundle_q.regWrite;
  assign ex_alu_ctrl   = exBundle_q.aluCtrl;
  assign ex_ra         = exBundle_q.ra;
  assign ex_rb         = exBundle_q.rb;
  assign ex_rc         = exBundle_q.rc;
  assign ex_rd1        = exBundle_q.rd1;
  assign ex_rd2        = exBundle_q.rd2;
  assign ex_rd3        = exBundle_q.rd3;
  assign ex_imm        = exBundle_q.imm;

endmodule

// File: tb/tb_decode_stage_v2.sv
// Bench for decode_stage_v2: directed scenarios followed by a random stream, all
// checked against a behavioural model of the decode stage kept in this file.
module tb_decode_stage_v2;

  localparam int DATA_W    = 24;
  localparam int PC_W      = 24;
  localparam int REG_IDX_W = 4;
  localparam int IMM_W     = 18;

  logic                 clk = 1'b0;
  logic                 rst, in_valid, in_ready, out_ready, flush, wb_we;
  logic [31:0]          inst;
  logic [PC_W-1:0]      pc;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [DATA_W-1:0]    wb_wd;
  logic                 ex_valid, ex_imm_src, ex_branch, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic [PC_W-1:0]      ex_pc;
  logic [1:0]           ex_op_type;
  logic [3:0]           ex_op_code, ex_alu_ctrl;
  logic [REG_IDX_W-1:0] ex_ra, ex_rb, ex_rc;
  logic [DATA_W-1:0]    ex_rd1, ex_rd2, ex_rd3, ex_imm;
  logic                 hazard_stall;

  always #5 clk = ~clk;

  decode_stage_v2 #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_IDX_W(REG_IDX_W), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
    .out_ready(out_ready), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op_type(ex_op_type), .ex_op_code(ex_op_code),
    .ex_imm_src(ex_imm_src), .ex_branch(ex_branch), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_rc(ex_rc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_rd3(ex_rd3), .ex_imm(ex_imm), .hazard_stall(hazard_stall)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: architectural registers plus the expected ID/EX contents.
  logic [DATA_W-1:0] refRegs [16];
  logic        mValid = 1'b0;
  logic [23:0] mPc = '0;
  logic [1:0]  mType = '0;
  logic [3:0]  mCode = '0;
  logic        mImmSrc = 1'b0, mBranch = 1'b0, mMemWrite = 1'b0, mMemToReg = 1'b0, mRegWrite = 1'b0;
  logic [3:0]  mRa = '0, mRb = '0, mRc = '0;
  logic [23:0] mRd1 = '0, mRd2 = '0, mRd3 = '0, mImm = '0;
  logic        lastReady, lastStall;
  logic [23:0] savedPc;

  task automatic checkVal(input string tag, input logic [146:0] obs, input logic [146:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] readRef(input logic [3:0] idx);
    return (wb_we && wb_rd == idx) ? wb_wd : refRegs[idx];
  endfunction

  function automatic logic [23:0] signExt(input logic [17:0] v);
    int unsigned x = v;
    if (x >= 131072) x = x + 32'h00FC_0000;
    return 24'(x);
  endfunction

  function automatic logic [31:0] mkInst(input logic [1:0] t, input logic [3:0] c,
                                         input logic [3:0] rc, input logic [3:0] ra,
                                         input logic [17:0] low);
    return {t, c, rc, ra, low};
  endfunction

  task automatic applyStimulus(input logic r, input logic iv, input logic [31:0] ins,
                               input logic [23:0] p, input logic ordy, input logic fl,
                               input logic we, input logic [3:0] rd, input logic [23:0] wd);
    rst = r; in_valid = iv; inst = ins; pc = p; out_ready = ordy; flush = fl;
    wb_we = we; wb_rd = rd; wb_wd = wd;
  endtask

  task automatic checkOutput();
    checkVal("ex_valid", ex_valid, mValid);
    checkVal("ex_bundle",
      {ex_pc, ex_op_type, ex_op_code, ex_imm_src, ex_branch, ex_mem_write, ex_mem_to_reg,
       ex_reg_write, ex_alu_ctrl, ex_ra, ex_rb, ex_rc, ex_rd1, ex_rd2, ex_rd3, ex_imm},
      {mPc, mType, mCode, mImmSrc, mBranch, mMemWrite, mMemToReg,
       mRegWrite, mCode, mRa, mRb, mRc, mRd1, mRd2, mRd3, mImm});
  endtask

  // One clock: check handshake outputs mid-cycle, advance the model at the edge, check ID/EX.
  task automatic stepCycle();
    logic [1:0]  t;
    logic [3:0]  c, ra, rb, rc;
    logic        adv, haz, expReady, expStall, accept;
    logic [23:0] v1, v2, v3;
    #1;
    t = inst[31:30]; c = inst[29:26]; rc = inst[25:22]; ra = inst[21:18]; rb = inst[17:14];
    adv = out_ready || !mValid;
    haz = in_valid && mValid && mMemToReg &&
          (mRc == ra || mRc == rb || (t == 2'b10 && c[0] && mRc == rc));
    expReady = !rst && adv && !haz && !flush;
    expStall = !rst && adv && haz && !flush;
    lastReady = in_ready;
    lastStall = hazard_stall;
    checkVal("in_ready", in_ready, expReady);
    checkVal("hazard_stall", hazard_stall, expStall);
    accept = in_valid && expReady;
    v1 = readRef(ra); v2 = readRef(rb); v3 = readRef(rc);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) refRegs[i] = '0;
      mValid = 0; mPc = '0; mType = '0; mCode = '0; mImmSrc = 0; mBranch = 0;
      mMemWrite = 0; mMemToReg = 0; mRegWrite = 0; mRa = '0; mRb = '0; mRc = '0;
      mRd1 = '0; mRd2 = '0; mRd3 = '0; mImm = '0;
    end else begin
      if (flush) mValid = 0;
      else if (adv) begin
        mValid = accept;
        if (accept) begin
          mPc = pc; mType = t; mCode = c; mRa = ra; mRb = rb; mRc = rc;
          mRd1 = v1; mRd2 = v2; mRd3 = v3; mImm = signExt(inst[17:0]);
          mImmSrc   = (t != 2'b00);
          mBranch   = (t == 2'b11);
          mMemWrite = (t == 2'b10) && c[0];
          mMemToReg = (t == 2'b10) && !c[0];
          mRegWrite = (t == 2'b00) || (t == 2'b01) || ((t == 2'b10) && !c[0]);
        end
      end
      if (wb_we) refRegs[wb_rd] = wb_wd;
    end
    #1;
    checkOutput();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) refRegs[i] = '0;
    // Reset must win over flush, write-back and a presented instruction.
    applyStimulus(1, 1, 32'h1234_5678, 24'h11, 1, 1, 1, 4'd7, 24'h777);
    stepCycle();
    stepCycle();

    applyStimulus(0, 0, 32'h0, 24'h0, 1, 0, 1, 4'd2, 24'd5);
    stepCycle();
    applyStimulus(0, 1, mkInst(2'b01, 4'b0011, 4'd1, 4'd2, 18'h3FFFF), 24'h100, 1, 0, 0, 4'd0, 24'h0);
    stepCycle();
    checkVal("aluimm_valid", ex_valid, 1'b1);
    checkVal("aluimm_rd1", ex_rd1, 24'd5);
    checkVal("aluimm_imm", ex_imm, 24'hFFFFFF);
    checkVal("aluimm_alu", ex_alu_ctrl, 4'd3);
    checkVal("aluimm_regw", ex_reg_write, 1'b1);

    applyStimulus(0, 1, mkInst(2'b00, 4'b0000, 4'd5, 4'd4, 18'h0), 24'h104, 1, 0, 1, 4'd4, 24'h00ABCD);
    stepCycle();
    checkVal("bypass_rd1", ex_rd1, 24'h00ABCD);

    applyStimulus(0, 1, mkInst(2'b10, 4'b0000, 4'd3, 4'd1, 18'h0), 24'h108, 1, 0, 0, 4'd0, 24'h0);
    stepCycle();
    applyStimulus(0, 1, mkInst(2'b00, 4'b0001, 4'd6, 4'd3, 18'h0), 24'h10C, 1, 0, 0, 4'd0, 24'h0);
    stepCycle();
    checkVal("lu_stall", lastStall, 1'b1);
    checkVal("lu_ready", lastReady, 1'b0);
    checkVal("lu_bubble", ex_valid, 1'b0);
    stepCycle();
    checkVal("lu_accept_pc", ex_pc, 24'h10C);

    savedPc = ex_pc;
    applyStimulus(0, 1, mkInst(2'b11, 4'b0101, 4'd2, 4'd7, 18'h12345), 24'h110, 0, 0, 0, 4'd0, 24'h0);
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkVal("bp_ready", lastReady, 1'b0);
      checkVal("bp_hold_pc", ex_pc, savedPc);
    end
    out_ready = 1;
    stepCycle();
    checkVal("bp_release_pc", ex_pc, 24'h110);

    applyStimulus(0, 1, mkInst(2'b00, 4'b0010, 4'd8, 4'd9, 18'h0), 24'h114, 0, 1, 0, 4'd0, 24'h0);
    stepCycle();
    checkVal("flush_valid", ex_valid, 1'b0);
    checkVal("flush_ready", lastReady, 1'b0);
    flush = 0; out_ready = 1;
    stepCycle();
    checkVal("flush_pending_pc", ex_pc, 24'h114);

    applyStimulus(0, 0, 32'h0, 24'h0, 1, 0, 1, 4'd3, 24'h000123);
    stepCycle();
    applyStimulus(0, 1, mkInst(2'b10, 4'b0010, 4'd3, 4'd0, 18'h0), 24'h120, 1, 0, 0, 4'd0, 24'h0);
    stepCycle();
    applyStimulus(1, 1, mkInst(2'b00, 4'b0000, 4'd1, 4'd3, 18'h0), 24'h124, 1, 0, 0, 4'd0, 24'h0);
    stepCycle();
    checkVal("rst_stall", lastStall, 1'b0);
    checkVal("rst_valid", ex_valid, 1'b0);
    rst = 0;
    stepCycle();
    checkVal("rst_r3", ex_rd1, 24'h0);

    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom % 64) == 0, ($urandom % 4) != 0,
                    mkInst(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom_range(0, 3)),
                           4'($urandom_range(0, 3)),
                           {4'($urandom_range(0, 3)), 14'($urandom)}),
                    24'($urandom), ($urandom % 4) != 0, ($urandom % 16) == 0,
                    1'($urandom), 4'($urandom_range(0, 3)), 24'($urandom));
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage_v2.md
DECODE_STAGE_V2 -- requirements
Module: decode_stage_v2

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 24: register/data width.
- PC_W, 24: program-counter width.
- REG_IDX_W, 4: register index width; register file holds 2**REG_IDX_W entries.
- IMM_W, 18: immediate field width, with IMM_W <= 32-6-2*REG_IDX_W and IMM_W <= DATA_W.
REQ-002 Ports SHALL be (name direction width meaning); one clock, reset synchronous and active-high:
- clk in 1: rising-edge clock.
- rst in 1: synchronous active-high reset.
- in_valid in 1: fetch presents an instruction.
- in_ready out 1: decode accepts it this cycle.
- inst in 32: instruction word.
- pc in PC_W: PC of inst.
- out_ready in 1: execute accepts the ID/EX register contents.
- flush in 1: kill the instruction in decode and in ID/EX.
- wb_we in 1: register-file write enable.
- wb_rd in REG_IDX_W: write index.
- wb_wd in DATA_W: write data.
- ex_valid out 1: ID/EX holds a real instruction.
- ex_pc out PC_W.
- ex_op_type out 2.
- ex_op_code out 4.
- ex_imm_src, ex_branch, ex_mem_write, ex_mem_to_reg, ex_reg_write out 1 each: control flags.
- ex_alu_ctrl out 4.
- ex_ra, ex_rb, ex_rc out REG_IDX_W each: register indices.
- ex_rd1, ex_rd2, ex_rd3 out DATA_W each: operand values.
- ex_imm out DATA_W: sign-extended immediate.
- hazard_stall out 1: load-use bubble is being inserted this cycle.

Function
REQ-003 Field split SHALL be: op_type=inst[31:30], op_code=inst[29:26], rc=next REG_IDX_W bits below, then ra, then rb; imm=inst[IMM_W-1:0].
REQ-004 ex_imm SHALL be imm sign-extended from bit IMM_W-1 to DATA_W.
REQ-005 Decode table:
- op_type 00 (ALU reg): reg_write=1, imm_src=0.
- op_type 01 (ALU imm): reg_write=1, imm_src=1.
- op_type 10 (memory): imm_src=1; op_code[0]=0 gives load (mem_to_reg=1, reg_write=1); op_code[0]=1 gives store (mem_write=1).
- op_type 11: branch=1, imm_src=1.
- alu_ctrl SHALL equal op_code. All flags not listed SHALL be 0.
REQ-006 Register file SHALL hold 2**REG_IDX_W x DATA_W entries, written on the rising edge when wb_we=1, with three combinational reads (ra, rb, rc).
REQ-007 Write-through bypass: when wb_we=1 and wb_rd equals a read index in the same cycle, that read SHALL return wb_wd.
REQ-008 advance = out_ready | ~ex_valid.
REQ-009 Load-use hazard = in_valid & ex_valid & ex_mem_to_reg & (ex_rc==ra | ex_rc==rb | (store & ex_rc==rc)).
REQ-010 in_ready SHALL equal advance & ~hazard & ~flush; hazard_stall SHALL equal advance & hazard & ~flush.
REQ-011 On an edge with advance=1:
- in_valid & in_ready: ID/EX loads the decoded bundle and ex_valid<=1.
- Otherwise, including a hazard: a bubble is inserted, ex_valid<=0, and other ex_* SHALL hold their values.
REQ-012 When advance=0, all ex_* SHALL hold; the bundle SHALL stay stable while ex_valid & ~out_ready.
REQ-013 flush=1 SHALL set ex_valid<=0 next edge regardless of out_ready, and the decode instruction SHALL NOT be accepted; flush outranks hazard and advance.
REQ-014 Latency SHALL be one cycle from accepted input to ex_valid; throughput SHALL be one instruction per cycle absent stalls.
REQ-015 A load-use hazard SHALL insert exactly one bubble when out_ready stays 1.

Reset
REQ-016 With rst=1 at an edge:
- ex_valid and all ex_* SHALL be 0.
- All register-file entries SHALL be 0.
- in_ready and hazard_stall SHALL be 0 while rst=1.
REQ-017 Reset SHALL override flush, write-back and any handshake in flight; the first accept SHALL be possible on the edge after rst falls.

Verification
REQ-018 Reset then ALU-imm: after rst, set r2=5; send inst op_type=01, op_code=0011, rc=1, ra=2, imm=0x3FFFF with out_ready=1 -> next cycle ex_valid=1, ex_rd1=5, ex_imm=0xFFFFFF, ex_alu_ctrl=3, ex_reg_write=1.
REQ-019 Bypass: wb_we=1, wb_rd=4, wb_wd=0x00ABCD in the same cycle as decoding ra=4 -> ex_rd1=0x00ABCD.
REQ-020 Load-use: a load to rc=3 followed by ALU reading ra=3 -> one cycle with hazard_stall=1, in_ready=0 and ex_valid=0 bubble, then the ALU instruction is accepted.
REQ-021 Backpressure: out_ready=0 for 3 cycles with ex_valid=1 -> ex_* unchanged, in_ready=0; release -> next instruction loads on the first edge.
REQ-022 Flush with out_ready=0 and ex_valid=1 -> ex_valid=0 next cycle and the pending input is not consumed.
REQ-023 Mid-stream reset: assert rst during a hazard stall -> ex_valid=0 and hazard_stall=0, and r3 reads 0 afterwards.
